alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Two-requester round-robin arbiter that time-shares the combinational ALU and prefix adder between two operand sources, e.g. the switch panel and a serial command port.
- Captures the granted request, drives the shared datapath operands, waits a fixed settle time, and registers R, SUM and COUT.
- Returns the registered result tagged with the requester ID over a valid/ready handshake.
- Sits between the requesters and the ALU/prefix instances, ahead of the display/LED logic.

Parameters:
- WA, 8, width of operand A, ALU result R and adder SUM
- WB, 5, width of operand B as supplied by requesters; zero-extended to WA on alu_b
- SETTLE, 1, cycles the datapath operands are held before the result is sampled (1..15)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester request valid, bit i = requester i
- req_ready  out  2  per-requester accept; a request transfers when valid & ready are both high
- req0_a / req1_a  in  WA  operand A
- req0_b / req1_b  in  WB  operand B
- req0_sel / req1_sel  in  3  ALU operation select
- req0_cin / req1_cin  in  1  adder carry-in
- alu_a  out  WA  shared datapath operand A (registered)
- alu_b  out  WA  shared operand B, {zeros, b} (registered)
- alu_sel  out  3  shared ALU select (registered)
- alu_cin  out  1  shared adder carry-in (registered)
- alu_r  in  WA  ALU result from datapath
- alu_sum  in  WA  prefix adder sum
- alu_cout  in  1  prefix adder carry-out
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accept
- rsp_id  out  1  requester that owns the result
- rsp_r  out  WA  registered ALU result
- rsp_sum  out  WA  registered sum
- rsp_cout  out  1  registered carry-out

Behaviour:
- Reset (async, while rst_n=0): state=IDLE, req_ready=0, rsp_valid=0, all alu_* and rsp_* outputs 0, last_grant=1 (so requester 0 wins first), settle counter 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is one-hot toward the arbitration winner and computed combinationally from req_valid and last_grant; no winner gives 00.
  - Winner: the only valid requester; if both are valid, the one not equal to last_grant.
  - On transfer: register a/b/sel/cin onto alu_*, set last_grant and rsp_id to the winner, load counter=SETTLE, go to EXEC.
- EXEC:
  - req_ready=00; counter decrements each cycle.
  - When counter reaches 1: sample alu_r, alu_sum, alu_cout into rsp_*, assert rsp_valid next cycle, go to RESP.
- RESP:
  - rsp_valid=1; rsp_* and alu_* held stable.
  - On rsp_valid & rsp_ready: rsp_valid drops next cycle, go to IDLE.
  - A new grant is only possible from IDLE, so the arbiter is never pipelined: one outstanding operation at a time.
- Latency: accept edge to rsp_valid high = SETTLE+1 cycles. With rsp_ready held high, throughput is one result per SETTLE+3 cycles.
- Requester side:
  - A requester dropping valid before it is granted is legal and has no effect.
  - A requester must hold its operands stable only in the accept cycle.
- Consumer side: holding rsp_ready=0 stalls indefinitely; req_ready stays 00 meanwhile.
- Widths: alu_b = zero-extension of WB bits to WA; no sign handling. rsp_* values are pass-through samples; the arbiter does no arithmetic.
- Reset mid-operation (EXEC or RESP): everything returns to reset values immediately. The in-flight result is discarded and no rsp_valid pulse is produced.
- rsp_ready asserted while rsp_valid=0: ignored.

Optional Feature:
- Macro: ALU_SHARE_ARBITER_STATS_EN.
- When defined:
  - Adds outputs grant_cnt0 and grant_cnt1, 16 bits each.
  - Each counter increments on every accept for its requester and saturates at 0xFFFF.
  - Both counters reset to 0 on reset.
- When undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Single request:
  - Stimulus: SETTLE=1, req0 a=0x5A, b=0x03, sel=0, cin=1; datapath model returns sum=0x5E, cout=0, r=0x5D.
  - Required: alu_b=0x03, rsp_valid 2 cycles after accept, rsp_id=0, rsp_sum=0x5E, rsp_cout=0.
- Simultaneous requests:
  - Stimulus: both req_valid held high with rsp_ready=1 after reset.
  - Required: grants alternate 0,1,0,1 over 4 operations; no requester is granted twice in a row.
- Backpressure:
  - Stimulus: rsp_ready=0 for 10 cycles while req1 is pending.
  - Required: rsp_* stable, req_ready=00 throughout; req1 is granted the cycle after the handshake completes.
- Carry-out:
  - Stimulus: a=0xFF, b=0x01, cin=0; datapath returns sum=0x00, cout=1.
  - Required: rsp_sum=0x00, rsp_cout=1. Also verify b=0x1F gives alu_b=0x1F, upper bits zero.
- Reset mid-EXEC:
  - Stimulus: SETTLE=4, pull rst_n low 2 cycles after accept.
  - Required: all outputs 0 asynchronously, no rsp_valid; the next grant after reset goes to requester 0.
- Stats (with ALU_SHARE_ARBITER_STATS_EN):
  - Stimulus: 3 grants to requester 0 and 2 to requester 1.
  - Required: grant_cnt0=3, grant_cnt1=2.
  - Stimulus: preload a counter near 0xFFFF via a force, then grant that requester again.
  - Required: the counter saturates at 0xFFFF.

Source files
------------

// File: rtl/alu_share_arbiter.sv
`timescale 1ns/1ps
// alu_share_arbiter
// Two-requester round-robin arbiter that time-shares one combinational ALU
// and prefix adder. A granted request is launched onto the shared alu_*
// operands and held for SETTLE cycles. The datapath result is then captured
// and returned to the owning requester over a valid/ready handshake.
// Only one operation is in flight at a time.
//
// Optional build macro: ALU_SHARE_ARBITER_STATS_EN adds the saturating
// 16-bit per-requester grant counters grant_cnt0 and grant_cnt1.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | arbitrating; req_ready points at the winner
// EXEC   | operands driven, settle counter running, result captured at 1
// RESP   | rsp_valid high, holding result until rsp_ready
module alu_share_arbiter #(
    parameter int WA     = 8,
    parameter int WB     = 5,
    parameter int SETTLE = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [WA-1:0] req0_a,
    input  logic [WB-1:0] req0_b,
    input  logic [2:0]    req0_sel,
    input  logic          req0_cin,
    input  logic [WA-1:0] req1_a,
    input  logic [WB-1:0] req1_b,
    input  logic [2:0]    req1_sel,
    input  logic          req1_cin,
    output logic [WA-1:0] alu_a,
    output logic [WA-1:0] alu_b,
    output logic [2:0]    alu_sel,
    output logic          alu_cin,
    input  logic [WA-1:0] alu_r,
    input  logic [WA-1:0] alu_sum,
    input  logic          alu_cout,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [WA-1:0] rsp_r,
    output logic [WA-1:0] rsp_sum,
    output logic          rsp_cout
`ifdef ALU_SHARE_ARBITER_STATS_EN
    ,
    output logic [15:0]   grant_cnt0,
    output logic [15:0]   grant_cnt1
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_last_grant;
    logic [3:0]    r_cnt;

    logic          w_any;
    logic          w_winner;
    logic          w_fire;
    logic [WA-1:0] w_a;
    logic [WB-1:0] w_b;
    logic [2:0]    w_sel;
    logic          w_cin;

    // Round-robin pick: a lone requester wins, on a tie the one not served last.
    always_comb begin
        w_any    = |req_valid;
        w_winner = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];
    end

    // Accept strobe toward the winner; held low during reset and outside IDLE.
    always_comb begin
        req_ready = 2'b00;
        if (rst_n && (r_state == S_IDLE) && w_any) begin
            req_ready[w_winner] = 1'b1;
        end
        w_fire = |(req_valid & req_ready);
    end

    // Operand mux for the winning requester.
    always_comb begin
        w_a   = w_winner ? req1_a   : req0_a;
        w_b   = w_winner ? req1_b   : req0_b;
        w_sel = w_winner ? req1_sel : req0_sel;
        w_cin = w_winner ? req1_cin : req0_cin;
    end

    // Arbitration FSM with registered datapath operands and response.
    // The capture at count 1 and the valid on the following edge give
    // SETTLE+1 cycles from accept to rsp_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_cnt        <= 4'd0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_sel      <= 3'd0;
            alu_cin      <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_r        <= '0;
            rsp_sum      <= '0;
            rsp_cout     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_fire) begin
                        alu_a        <= w_a;
                        alu_b        <= WA'(w_b);
                        alu_sel      <= w_sel;
                        alu_cin      <= w_cin;
                        r_last_grant <= w_winner;
                        rsp_id       <= w_winner;
                        r_cnt        <= 4'(SETTLE);
                        r_state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_cnt == 4'd1) begin
                        rsp_r    <= alu_r;
                        rsp_sum  <= alu_sum;
                        rsp_cout <= alu_cout;
                        r_cnt    <= 4'd0;
                    end else if (r_cnt == 4'd0) begin
                        rsp_valid <= 1'b1;
                        r_state   <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SHARE_ARBITER_STATS_EN
    logic [15:0] r_grant_cnt0;
    logic [15:0] r_grant_cnt1;

    // Saturating per-requester accept counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_cnt0 <= 16'd0;
            r_grant_cnt1 <= 16'd0;
        end else if (w_fire) begin
            if (!w_winner && (r_grant_cnt0 != 16'hFFFF)) begin
                r_grant_cnt0 <= r_grant_cnt0 + 16'd1;
            end
            if (w_winner && (r_grant_cnt1 != 16'hFFFF)) begin
                r_grant_cnt1 <= r_grant_cnt1 + 16'd1;
            end
        end
    end

    assign grant_cnt0 = r_grant_cnt0;
    assign grant_cnt1 = r_grant_cnt1;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
`timescale 1ns/1ps
// Directed bench for alu_share_arbiter. Two instances share the request and
// consumer inputs: u_dut1 with SETTLE=1 and u_dut4 with SETTLE=4. Each has
// its own behavioural ALU/adder model. Expected values are hand-computed.
module tb_alu_share_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req_valid = 2'b00;
    logic [7:0] r0a = '0, r1a = '0;
    logic [4:0] r0b = '0, r1b = '0;
    logic [2:0] r0sel = '0, r1sel = '0;
    logic       r0cin = 1'b0, r1cin = 1'b0;
    logic       rsp_ready = 1'b0;

    logic [1:0] d1_req_ready, d4_req_ready;
    logic [7:0] d1_alu_a, d1_alu_b, d1_alu_r, d1_alu_sum, d1_rsp_r, d1_rsp_sum;
    logic [7:0] d4_alu_a, d4_alu_b, d4_alu_r, d4_alu_sum, d4_rsp_r, d4_rsp_sum;
    logic [2:0] d1_alu_sel, d4_alu_sel;
    logic       d1_alu_cin, d1_alu_cout, d1_rsp_valid, d1_rsp_id, d1_rsp_cout;
    logic       d4_alu_cin, d4_alu_cout, d4_rsp_valid, d4_rsp_id, d4_rsp_cout;
`ifdef ALU_SHARE_ARBITER_STATS_EN
    logic [15:0] d1_cnt0, d1_cnt1, d4_cnt0, d4_cnt1;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] sel);
        case (sel)
            3'd0:    alu_fn = a + b;
            3'd1:    alu_fn = a - b;
            3'd2:    alu_fn = a & b;
            3'd3:    alu_fn = a | b;
            3'd4:    alu_fn = a ^ b;
            default: alu_fn = a;
        endcase
    endfunction

    always_comb begin
        d1_alu_r = alu_fn(d1_alu_a, d1_alu_b, d1_alu_sel);
        {d1_alu_cout, d1_alu_sum} = {1'b0, d1_alu_a} + {1'b0, d1_alu_b} + 9'(d1_alu_cin);
        d4_alu_r = alu_fn(d4_alu_a, d4_alu_b, d4_alu_sel);
        {d4_alu_cout, d4_alu_sum} = {1'b0, d4_alu_a} + {1'b0, d4_alu_b} + 9'(d4_alu_cin);
    end

    alu_share_arbiter #(.WA(8), .WB(5), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(d1_req_ready),
        .req0_a(r0a), .req0_b(r0b), .req0_sel(r0sel), .req0_cin(r0cin),
        .req1_a(r1a), .req1_b(r1b), .req1_sel(r1sel), .req1_cin(r1cin),
        .alu_a(d1_alu_a), .alu_b(d1_alu_b), .alu_sel(d1_alu_sel), .alu_cin(d1_alu_cin),
        .alu_r(d1_alu_r), .alu_sum(d1_alu_sum), .alu_cout(d1_alu_cout),
        .rsp_valid(d1_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(d1_rsp_id),
        .rsp_r(d1_rsp_r), .rsp_sum(d1_rsp_sum), .rsp_cout(d1_rsp_cout)
`ifdef ALU_SHARE_ARBITER_STATS_EN
        , .grant_cnt0(d1_cnt0), .grant_cnt1(d1_cnt1)
`endif
    );

    alu_share_arbiter #(.WA(8), .WB(5), .SETTLE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(d4_req_ready),
        .req0_a(r0a), .req0_b(r0b), .req0_sel(r0sel), .req0_cin(r0cin),
        .req1_a(r1a), .req1_b(r1b), .req1_sel(r1sel), .req1_cin(r1cin),
        .alu_a(d4_alu_a), .alu_b(d4_alu_b), .alu_sel(d4_alu_sel), .alu_cin(d4_alu_cin),
        .alu_r(d4_alu_r), .alu_sum(d4_alu_sum), .alu_cout(d4_alu_cout),
        .rsp_valid(d4_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(d4_rsp_id),
        .rsp_r(d4_rsp_r), .rsp_sum(d4_rsp_sum), .rsp_cout(d4_rsp_cout)
`ifdef ALU_SHARE_ARBITER_STATS_EN
        , .grant_cnt0(d4_cnt0), .grant_cnt1(d4_cnt1)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        req_valid = 2'b11;
        #1;
        checks++;
        if (d1_req_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_req_ready: got %b want 00", d1_req_ready);
        end
        checks++;
        if ({d1_rsp_valid, d1_rsp_id, d1_rsp_r, d1_rsp_sum, d1_rsp_cout} !== '0) begin
            errors++;
            $display("FAIL reset_rsp: got v=%b id=%b r=%h s=%h c=%b want all 0",
                     d1_rsp_valid, d1_rsp_id, d1_rsp_r, d1_rsp_sum, d1_rsp_cout);
        end
        checks++;
        if ({d1_alu_a, d1_alu_b, d1_alu_sel, d1_alu_cin} !== '0) begin
            errors++;
            $display("FAIL reset_alu: got a=%h b=%h sel=%h cin=%b want all 0",
                     d1_alu_a, d1_alu_b, d1_alu_sel, d1_alu_cin);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (d1_req_ready !== 2'b01) begin
            errors++;
            $display("FAIL reset_first_winner: got %b want 01", d1_req_ready);
        end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        r0a = 8'h5A; r0b = 5'h03; r0sel = 3'd0; r0cin = 1'b1;
        req_valid = 2'b01;
        #1;
        checks++;
        if (d1_req_ready !== 2'b01) begin
            errors++;
            $display("FAIL single_ready: got %b want 01", d1_req_ready);
        end
        tick();
        req_valid = 2'b00;
        checks++;
        if (d1_alu_a !== 8'h5A || d1_alu_b !== 8'h03 || d1_alu_cin !== 1'b1 ||
            d1_alu_sel !== 3'd0) begin
            errors++;
            $display("FAIL single_operands: got a=%h b=%h sel=%h cin=%b want 5a 03 0 1",
                     d1_alu_a, d1_alu_b, d1_alu_sel, d1_alu_cin);
        end
        checks++;
        if (d1_req_ready !== 2'b00 || d1_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_exec1: got ready=%b valid=%b want 00 0",
                     d1_req_ready, d1_rsp_valid);
        end
        tick();
        checks++;
        if (d1_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_latency_early: got valid=%b want 0", d1_rsp_valid);
        end
        tick();
        checks++;
        if (d1_rsp_valid !== 1'b1 || d1_rsp_id !== 1'b0 || d1_rsp_sum !== 8'h5E ||
            d1_rsp_cout !== 1'b0 || d1_rsp_r !== 8'h5D) begin
            errors++;
            $display("FAIL single_rsp: got v=%b id=%b r=%h s=%h c=%b want 1 0 5d 5e 0",
                     d1_rsp_valid, d1_rsp_id, d1_rsp_r, d1_rsp_sum, d1_rsp_cout);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (d1_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp_drop: got valid=%b want 0", d1_rsp_valid);
        end
    endtask

    task automatic test_alternate();
        int n;
        do_reset();
        r0a = 8'h11; r0b = 5'h01; r0sel = 3'd0; r0cin = 1'b0;
        r1a = 8'h22; r1b = 5'h02; r1sel = 3'd0; r1cin = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (d1_req_ready === 2'b00 && n < 20) begin
                tick();
                n++;
            end
            checks++;
            if (n >= 20) begin
                errors++;
                $display("FAIL alt_timeout: op %0d got no grant in %0d cycles want grant", k, n);
            end
            checks++;
            if (d1_req_ready !== (k[0] ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL alt_grant: op %0d got %b want %b", k, d1_req_ready,
                         k[0] ? 2'b10 : 2'b01);
            end
            if (k > 0) begin
                checks++;
                if (n + 1 !== 4) begin
                    errors++;
                    $display("FAIL alt_throughput: op %0d got %0d cycles want 4", k, n + 1);
                end
            end
            tick();
            checks++;
            if (d1_rsp_id !== k[0] || d1_alu_a !== (k[0] ? 8'h22 : 8'h11)) begin
                errors++;
                $display("FAIL alt_owner: op %0d got id=%b a=%h want id=%b a=%h", k,
                         d1_rsp_id, d1_alu_a, k[0], k[0] ? 8'h22 : 8'h11);
            end
        end
        req_valid = 2'b00;
        repeat (4) tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        r0a = 8'h10; r0b = 5'h02; r0sel = 3'd0; r0cin = 1'b0;
        r1a = 8'h44; r1b = 5'h05; r1sel = 3'd2; r1cin = 1'b0;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b10;
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (d1_rsp_valid !== 1'b1 || d1_rsp_r !== 8'h12 || d1_rsp_sum !== 8'h12 ||
                d1_rsp_cout !== 1'b0 || d1_rsp_id !== 1'b0 || d1_req_ready !== 2'b00 ||
                d1_alu_a !== 8'h10) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d got v=%b r=%h s=%h id=%b rdy=%b a=%h want 1 12 12 0 00 10",
                         i, d1_rsp_valid, d1_rsp_r, d1_rsp_sum, d1_rsp_id, d1_req_ready, d1_alu_a);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (d1_rsp_valid !== 1'b0 || d1_req_ready !== 2'b10) begin
            errors++;
            $display("FAIL bp_release: got v=%b rdy=%b want 0 10", d1_rsp_valid, d1_req_ready);
        end
        tick();
        req_valid = 2'b00;
        checks++;
        if (d1_alu_a !== 8'h44 || d1_alu_b !== 8'h05 || d1_alu_sel !== 3'd2 ||
            d1_rsp_id !== 1'b1) begin
            errors++;
            $display("FAIL bp_req1_grant: got a=%h b=%h sel=%h id=%b want 44 05 2 1",
                     d1_alu_a, d1_alu_b, d1_alu_sel, d1_rsp_id);
        end
        tick();
        tick();
        checks++;
        if (d1_rsp_valid !== 1'b1 || d1_rsp_r !== 8'h04 || d1_rsp_sum !== 8'h49 ||
            d1_rsp_cout !== 1'b0) begin
            errors++;
            $display("FAIL bp_req1_rsp: got v=%b r=%h s=%h c=%b want 1 04 49 0",
                     d1_rsp_valid, d1_rsp_r, d1_rsp_sum, d1_rsp_cout);
        end
    endtask

    task automatic test_carry();
        do_reset();
        rsp_ready = 1'b1;
        r0a = 8'hFF; r0b = 5'h01; r0sel = 3'd0; r0cin = 1'b0;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        checks++;
        if (d1_rsp_valid !== 1'b1 || d1_rsp_sum !== 8'h00 || d1_rsp_cout !== 1'b1 ||
            d1_rsp_r !== 8'h00) begin
            errors++;
            $display("FAIL carry_rsp: got v=%b r=%h s=%h c=%b want 1 00 00 1",
                     d1_rsp_valid, d1_rsp_r, d1_rsp_sum, d1_rsp_cout);
        end
        tick();
        r1a = 8'h01; r1b = 5'h1F; r1sel = 3'd4; r1cin = 1'b1;
        req_valid = 2'b10;
        #1;
        checks++;
        if (d1_req_ready !== 2'b10) begin
            errors++;
            $display("FAIL carry_ready1: got %b want 10", d1_req_ready);
        end
        tick();
        req_valid = 2'b00;
        checks++;
        if (d1_alu_b !== 8'h1F) begin
            errors++;
            $display("FAIL zext_b: got %h want 1f", d1_alu_b);
        end
        tick();
        tick();
        checks++;
        if (d1_rsp_valid !== 1'b1 || d1_rsp_id !== 1'b1 || d1_rsp_sum !== 8'h21 ||
            d1_rsp_cout !== 1'b0 || d1_rsp_r !== 8'h1E) begin
            errors++;
            $display("FAIL zext_rsp: got v=%b id=%b r=%h s=%h c=%b want 1 1 1e 21 0",
                     d1_rsp_valid, d1_rsp_id, d1_rsp_r, d1_rsp_sum, d1_rsp_cout);
        end
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_exec();
        int seen;
        do_reset();
        rsp_ready = 1'b1;
        r0a = 8'h33; r0b = 5'h04; r0sel = 3'd0; r0cin = 1'b0;
        req_valid = 2'b01;
        #1;
        checks++;
        if (d4_req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rme_ready: got %b want 01", d4_req_ready);
        end
        tick();
        req_valid = 2'b00;
        checks++;
        if (d4_alu_a !== 8'h33 || d4_alu_b !== 8'h04) begin
            errors++;
            $display("FAIL rme_operands: got a=%h b=%h want 33 04", d4_alu_a, d4_alu_b);
        end
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({d4_req_ready, d4_rsp_valid, d4_rsp_id, d4_rsp_r, d4_rsp_sum, d4_rsp_cout,
             d4_alu_a, d4_alu_b, d4_alu_sel, d4_alu_cin} !== '0) begin
            errors++;
            $display("FAIL rme_async_clear: got rdy=%b v=%b a=%h b=%h sel=%h cin=%b want all 0",
                     d4_req_ready, d4_rsp_valid, d4_alu_a, d4_alu_b, d4_alu_sel, d4_alu_cin);
        end
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (d4_rsp_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL rme_no_valid: got %0d valid cycles want 0", seen);
        end
        req_valid = 2'b11;
        #1;
        checks++;
        if (d4_req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rme_next_grant: got %b want 01", d4_req_ready);
        end
        req_valid = 2'b00;
        rsp_ready = 1'b0;
    endtask

`ifdef ALU_SHARE_ARBITER_STATS_EN
    task automatic test_stats();
        int n;
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        #1;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (d1_req_ready === 2'b00 && n < 20) begin
                tick();
                n++;
            end
            checks++;
            if (n >= 20) begin
                errors++;
                $display("FAIL stats_timeout: op %0d got no grant want grant", k);
            end
            tick();
        end
        req_valid = 2'b00;
        repeat (4) tick();
        checks++;
        if (d1_cnt0 !== 16'd3 || d1_cnt1 !== 16'd2) begin
            errors++;
            $display("FAIL stats_counts: got cnt0=%0d cnt1=%0d want 3 2", d1_cnt0, d1_cnt1);
        end
        force u_dut1.r_grant_cnt0 = 16'hFFFE;
        #1;
        release u_dut1.r_grant_cnt0;
        req_valid = 2'b01;
        #1;
        for (int k = 0; k < 2; k++) begin
            n = 0;
            while (d1_req_ready === 2'b00 && n < 20) begin
                tick();
                n++;
            end
            tick();
            checks++;
            if (d1_cnt0 !== 16'hFFFF) begin
                errors++;
                $display("FAIL stats_saturate: op %0d got %h want ffff", k, d1_cnt0);
            end
        end
        req_valid = 2'b00;
        repeat (4) tick();
        checks++;
        if (d1_cnt1 !== 16'd2) begin
            errors++;
            $display("FAIL stats_cnt1_hold: got %0d want 2", d1_cnt1);
        end
        rsp_ready = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_carry();
        test_reset_mid_exec();
`ifdef ALU_SHARE_ARBITER_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
